bus_arb: RTL and testbench
==========================

Name: bus_arb

Overview:
- Round-robin arbiter and sequencer for one shared register/bus resource inside Tom.
- Shares the resource between NREQ requesters using a level req/gnt handshake.
- Enforces a programmable burst limit, an optional lock, and a one-cycle turnaround gap between owners.
- Sits between the requesting state machines and the resource's write-enable/mux-select logic; gnt_id drives the mux select.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of gnt_id; must satisfy 2^IDW >= NREQ.
- CNT_W, 8, width of the burst counter, burst_max and tmo_max.

Ports:
- sys_clk  in  1  sole clock; all state changes on its rising edge.
- resl  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level; held high for as long as the resource is wanted.
- lock  in  NREQ  per-requester lock; when the owner's bit is high, the owner is not pre-empted.
- burst_max  in  CNT_W  maximum grant length in cycles before pre-emption; 0 = unlimited.
- tmo_max  in  CNT_W  lock timeout limit; used only with ARB_TIMEOUT_EN.
- err_clr  in  1  clears err.
- gnt  out  NREQ  one-hot grant, registered.
- gnt_id  out  IDW  binary index of the owner; holds its last value when gnt=0.
- busy  out  1  high while in GRANT.
- preempt  out  1  one-cycle pulse when a grant is ended by the burst limit.
- err  out  1  sticky lock-timeout flag.

Behaviour:
- Reset (resl low, asynchronous): state=IDLE, gnt=0, gnt_id=0, busy=0, preempt=0, err=0, count=0, last=NREQ-1 (so requester 0 wins first).
- Arbitration function:
  - winner = first i with req[i]=1, searching last+1, last+2, ... with modulo-NREQ wrap.
  - Computed combinationally from the current req.
  - The winner is registered into gnt/gnt_id, and last<=winner, on the arbitrating edge.
- States:
  - IDLE: gnt=0. If any req is high, go to GRANT and assert gnt for the winner at the next edge; latency req->gnt is 1 cycle. Otherwise stay in IDLE.
  - GRANT: gnt held, busy=1, count increments each cycle (saturating at all-ones).
    - Exit to GAP when req[owner]=0. gnt drops at that edge.
    - Exit to GAP when burst_max!=0, count+1 >= burst_max, some other req is high, and lock[owner]=0. preempt pulses for 1 cycle coincident with the GAP state.
    - Otherwise stay in GRANT.
    - A request-drop exit takes priority over pre-emption; preempt stays 0 in that case.
  - GAP: gnt=0, busy=0 for exactly 1 cycle, count<=0.
    - Arbitrate as in IDLE: next state is GRANT if any req is high, else IDLE.
    - A pre-empted owner still requesting is eligible, but it ranks last under round-robin.
- A single requester with its req continuously high is never pre-empted (no other req pending); count saturates.
- Any req bit rising during GRANT does not disturb the current grant.
- Owner lock raised mid-grant suppresses pre-emption from that cycle onward.
- gnt is never asserted to a requester whose req was low at the arbitrating edge.
- At most one gnt bit is ever high.
- Reset mid-grant drops gnt immediately (asynchronously).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when lock[owner]=1, tmo_max!=0, count+1 >= tmo_max and another req is pending, the grant is forced to GAP regardless of lock.
  - err is set (sticky) and preempt pulses.
  - err clears when err_clr=1; a set in the same cycle as err_clr wins.
- Undefined: lock is honoured indefinitely, tmo_max and err_clr are ignored, and err is tied 0.

Test Plan:
- Reset, then req=4'b0001 -> gnt=4'b0001 and gnt_id=0 one cycle later; drop req -> gnt=0, GAP, then IDLE.
- req=4'b1111 held, burst_max=4, lock=0 -> grants in order 0,1,2,3,0, each 4 cycles long, each separated by one gnt=0 cycle, with a preempt pulse per handover.
- Owner 2 granted, lock[2]=1, req=4'b0111, burst_max=3 (macro off) -> gnt stays 4'b0100 for 50+ cycles, preempt=0.
- Same setup as the previous case, macro on, tmo_max=10 -> gnt drops after 10 cycles, err=1 and preempt pulses; next grant goes to 0; err_clr=1 -> err=0 on the next cycle.
- req=4'b0010 alone, burst_max=2 -> no pre-emption, count saturates at 255, gnt stays 4'b0010.
- resl asserted while gnt=4'b1000 -> gnt=0 immediately; after release with req=4'b1001, requester 0 is granted first.

Source files
------------

// File: rtl/bus_arb.sv
// Round-robin arbiter for one shared resource: level req/gnt handshake, burst limit,
// owner lock and a one-cycle gap between owners. Optional lock timeout under ARB_TIMEOUT_EN.
module bus_arb #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             resl,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  lock,
    input  logic [CNT_W-1:0] burst_max,
    input  logic [CNT_W-1:0] tmo_max,
    input  logic             err_clr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             preempt,
    output logic             err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             preempt_q, preempt_d;

    // Candidate k is the requester k+1 places after the last owner, wrapped modulo NREQ.
    logic [IDW-1:0]  cand [NREQ];
    logic [NREQ-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum          = {1'b0, last_q} + (IDW+1)'(gi + 1);
            assign cand[gi]     = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                          : sum[IDW-1:0];
            assign cand_req[gi] = req[cand[gi]];
        end
    endgenerate

    logic           win_found;
    logic [IDW-1:0] win_id;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && cand_req[k]) begin
                win_found = 1'b1;
                win_id    = cand[k];
            end
        end
    end

    logic [CNT_W:0] count_inc;
    logic           req_own;
    logic           lock_own;
    logic           others;
    logic           burst_hit;
    logic           tmo_hit;

    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign req_own   = req[gnt_id_q];
    assign lock_own  = lock[gnt_id_q];
    assign others    = |(req & ~gnt_q);
    assign burst_hit = (burst_max != '0) && (count_inc >= {1'b0, burst_max})
                       && others && !lock_own;

`ifdef ARB_TIMEOUT_EN
    assign tmo_hit = lock_own && (tmo_max != '0) && (count_inc >= {1'b0, tmo_max}) && others;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        count_d   = count_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_GRANT: begin
                if (!req_own) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (burst_hit || tmo_hit) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    count_d   = '0;
                    preempt_d = 1'b1;
                end else if (count_q != '1) begin
                    count_d = count_inc[CNT_W-1:0];
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; GAP simply lasts one cycle.
                count_d = '0;
                if (win_found) begin
                    state_d  = ST_GRANT;
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_d = win_id;
                    last_d   = win_id;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge resl) begin
        if (!resl) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_q    <= IDW'(NREQ - 1);
            count_q   <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            count_q   <= count_d;
            preempt_q <= preempt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (err_clr)
            err_d = 1'b0;
        if (state_q == ST_GRANT && req_own && tmo_hit)
            err_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge resl) begin
        if (!resl)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^{tmo_max, err_clr};
    assign err        = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == ST_GRANT);
    assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: behavioural owner/tenure model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_bus_arb;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNT_W = 8;

    logic             sys_clk = 1'b0;
    logic             resl    = 1'b0;
    logic [NREQ-1:0]  req     = '0;
    logic [NREQ-1:0]  lock    = '0;
    logic [CNT_W-1:0] burst_max = '0;
    logic [CNT_W-1:0] tmo_max   = '0;
    logic             err_clr   = 1'b0;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             busy;
    logic             preempt;
    logic             err;

    bus_arb #(.NREQ(NREQ), .IDW(IDW), .CNT_W(CNT_W)) dut (
        .sys_clk   (sys_clk),
        .resl      (resl),
        .req       (req),
        .lock      (lock),
        .burst_max (burst_max),
        .tmo_max   (tmo_max),
        .err_clr   (err_clr),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .preempt   (preempt),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource, how many cycles the tenure has run, last winner.
    int m_owner = -1;
    int m_id    = 0;
    int m_last  = NREQ - 1;
    int m_held  = 0;
    bit m_pre   = 0;
    bit m_err   = 0;
    int m_cnt1;
    bit m_others;

    always @(posedge sys_clk or negedge resl) begin
        if (!resl) begin
            m_owner = -1; m_id = 0; m_last = NREQ - 1; m_held = 0; m_pre = 0; m_err = 0;
        end else begin
            m_pre = 0;
            if (m_owner >= 0) begin
                m_cnt1   = m_held + 1;
                m_others = 0;
                for (int i = 0; i < NREQ; i++)
                    if (i != m_owner && req[i]) m_others = 1;
                if (!req[m_owner]) begin
                    m_owner = -1;
                end else if (m_others && burst_max != 0 && m_cnt1 >= int'(burst_max)
                             && !lock[m_owner]) begin
                    m_owner = -1; m_pre = 1;
`ifdef ARB_TIMEOUT_EN
                end else if (m_others && lock[m_owner] && tmo_max != 0
                             && m_cnt1 >= int'(tmo_max)) begin
                    m_owner = -1; m_pre = 1; m_err = 1;
`endif
                end else begin
                    m_held = (m_held >= 255) ? 255 : m_held + 1;
                end
`ifdef ARB_TIMEOUT_EN
                if (!m_pre || !m_err) ;
`endif
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % NREQ]) begin
                        m_owner = (m_last + k) % NREQ;
                    end
                end
                if (m_owner >= 0) begin
                    m_id = m_owner; m_last = m_owner; m_held = 0;
                end
            end
`ifdef ARB_TIMEOUT_EN
            if (!(m_pre && m_owner < 0 && m_err) && err_clr) m_err = 0;
`endif
        end
    end

    bit chk_en = 0;
    logic [NREQ-1:0] gnt_prev = '0;

    // Per-cycle comparison of all outputs against the model.
    always @(negedge sys_clk) begin
        if (resl && chk_en) begin
            chk("gnt",     int'(gnt),     (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("gnt_id",  int'(gnt_id),  m_id);
            chk("busy",    int'(busy),    (m_owner >= 0) ? 1 : 0);
            chk("preempt", int'(preempt), int'(m_pre));
            chk("err",     int'(err),     int'(m_err));
            if (gnt != 0 && gnt_prev == 0)
                $display("[TB] t=%0t grant -> requester %0d (req=%b lock=%b)",
                         $time, gnt_id, req, lock);
        end
        gnt_prev = gnt;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset;
        @(negedge sys_clk);
        resl = 1'b0; req = '0; lock = '0; err_clr = 1'b0;
        cyc(2);
        resl = 1'b1;
    endtask

    int seq_gnt [];
    int idx;

    initial begin
        cyc(2);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_busy", int'(busy), 0);
        resl = 1'b1;
        chk_en = 1;

        // Single requester, then drop: GAP then IDLE.
        req = 4'b0001;
        cyc(1);
        chk("t1_gnt", int'(gnt), 1);
        chk("t1_id", int'(gnt_id), 0);
        req = 4'b0000;
        cyc(1);
        chk("t1_drop_gnt", int'(gnt), 0);
        cyc(2);
        chk("t1_idle_busy", int'(busy), 0);
        $display("[TB] single request/drop done");

        // All requesting, burst 4: 0,1,2,3,0 each 4 cycles with a preempting gap.
        do_reset();
        burst_max = 8'd4;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(1);
                chk("t2_gnt", int'(gnt), 1 << (g % 4));
            end
            if (g < 4) begin
                cyc(1);
                chk("t2_gap_gnt", int'(gnt), 0);
                chk("t2_gap_preempt", int'(preempt), 1);
            end
        end
        $display("[TB] round-robin burst sequence done");

        // Owner 2 locked with others pending.
        do_reset();
        burst_max = 8'd3;
        tmo_max   = 8'd10;
        req = 4'b0100;
        cyc(1);
        chk("t3_gnt_start", int'(gnt), 4);
        req  = 4'b0111;
        lock = 4'b0100;
`ifdef ARB_TIMEOUT_EN
        cyc(9);
        chk("t3_gnt_held", int'(gnt), 4);
        cyc(1);
        chk("t3_tmo_gnt", int'(gnt), 0);
        chk("t3_tmo_err", int'(err), 1);
        chk("t3_tmo_pre", int'(preempt), 1);
        cyc(1);
        chk("t3_next_gnt", int'(gnt), 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t3_err_clr", int'(err), 0);
`else
        for (int c = 0; c < 55; c++) begin
            cyc(1);
            chk("t3_lock_gnt", int'(gnt), 4);
            chk("t3_lock_pre", int'(preempt), 0);
        end
`endif
        $display("[TB] lock scenario done");

        // Lone requester never pre-empted; count saturates.
        do_reset();
        lock = '0;
        burst_max = 8'd2;
        req = 4'b0010;
        cyc(1);
        for (int c = 0; c < 300; c++) begin
            cyc(1);
            if (c % 50 == 0) chk("t5_gnt", int'(gnt), 2);
        end
        $display("[TB] lone requester done");

        // Asynchronous reset mid-grant.
        do_reset();
        req = 4'b1000;
        cyc(1);
        chk("t6_gnt", int'(gnt), 8);
        #2 resl = 1'b0;
        #1 chk("t6_async_gnt", int'(gnt), 0);
        req = 4'b1001;
        @(negedge sys_clk);
        resl = 1'b1;
        cyc(1);
        chk("t6_after_gnt", int'(gnt), 1);
        $display("[TB] async reset done");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 15) == 0) lock = NREQ'($urandom_range(0, 15)) & NREQ'($urandom_range(0, 15));
            if (c % 100 == 0) begin
                burst_max = CNT_W'($urandom_range(0, 6));
                tmo_max   = CNT_W'($urandom_range(0, 12));
            end
            err_clr = ($urandom_range(0, 7) == 0);
        end
        cyc(1);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
